// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the HI/LO multiply/divide unit
package muldiv_pkg;

    localparam int DEFAULT_XLEN = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// rtl/muldiv_iter_dp.sv - unsigned shift-add / restoring shift-subtract iteration datapath
module muldiv_iter_dp
    import muldiv_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic              last_o
);

    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              div_q, div_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        acc_d     = acc_q;
        b_d       = b_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
        if (load_i) begin
            acc_d = {{XLEN{1'b0}}, a_i};
            b_d   = b_i;
            div_d = is_div_i;
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
                // bit XLEN of the trial is the borrow: set means the divisor did not fit
                if (!div_trial[XLEN]) begin
                    acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                end
            end else begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o  = acc_q;
    assign last_o = (cnt_q == CW'(XLEN - 1));

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] mt_wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic            neg_q, neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            div0_q, div0_d;
    logic [XLEN-1:0] rs_raw_q, rs_raw_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            done_q, done_d;

    logic            is_signed_in;
    logic            rs_neg_in;
    logic            rt_neg_in;
    logic [XLEN-1:0] rs_mag;
    logic [XLEN-1:0] rt_mag;
    logic            dp_load;
    logic            dp_step;
    logic            dp_last;
    logic [2*XLEN-1:0] dp_acc;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    // The datapath only ever sees magnitudes; signs are restored in FIX
    assign is_signed_in = ~op[0];
    assign rs_neg_in    = is_signed_in & rs_data[XLEN-1];
    assign rt_neg_in    = is_signed_in & rt_data[XLEN-1];
    assign rs_mag       = rs_neg_in ? -rs_data : rs_data;
    assign rt_mag       = rt_neg_in ? -rt_data : rt_data;
    assign dp_load      = (state_q == ST_IDLE) && start;
    assign dp_step      = (state_q == ST_CALC);

    muldiv_iter_dp #(
        .XLEN(XLEN)
    ) u_iter_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (dp_load),
        .step_i   (dp_step),
        .is_div_i (op[1]),
        .a_i      (rs_mag),
        .b_i      (rt_mag),
        .acc_o    (dp_acc),
        .last_o   (dp_last)
    );

    assign prod_fix = neg_q ? -dp_acc : dp_acc;
    assign quot_fix = neg_q ? -dp_acc[XLEN-1:0] : dp_acc[XLEN-1:0];
    assign rem_fix  = rem_neg_q ? -dp_acc[2*XLEN-1:XLEN] : dp_acc[2*XLEN-1:XLEN];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        rs_raw_d  = rs_raw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = op_e'(op);
                    neg_d     = rs_neg_in ^ rt_neg_in;
                    rem_neg_d = rs_neg_in;
                    div0_d    = (rt_data == '0);
                    rs_raw_d  = rs_data;
                    state_d   = ST_CALC;
                end else begin
                    if (hi_we) hi_d = mt_wdata;
                    if (lo_we) lo_d = mt_wdata;
                end
            end
            ST_CALC: begin
                if (dp_last) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (op_is_div(op_q)) begin
                    if (div0_q) begin
                        hi_d = rs_raw_q;
                        lo_d = {XLEN{1'b1}};
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end else begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MULT;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            rs_raw_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            rs_raw_q  <= rs_raw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] mt_wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail = 0;

    muldiv_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .mt_wdata (mt_wdata),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result: {hi, lo}
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin p = sa * sb; return p; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; return p; end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Transaction-level model: an accepted op occupies the unit for 33 edges
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_done = 1'b0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        logic [63:0] res;
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end else if (start) begin
                res = model(op, rs_data, rt_data);
                p_hi = res[63:32];
                p_lo = res[31:0];
                m_left = 33;
            end else begin
                if (hi_we) m_hi = mt_wdata;
                if (lo_we) m_lo = mt_wdata;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_busy", {31'b0, busy}, {31'b0, m_left > 0});
        chk("cmp_done", {31'b0, done}, {31'b0, m_done});
        chk("cmp_hi", hi, m_hi);
        chk("cmp_lo", lo, m_lo);
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
    endtask

    // Step negedges after E0 until done; optionally inject ignored start/MTHI mid-operation
    task automatic wait_done(input bit inject, output int busy_cnt, output bit seen);
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            start = 1'b0;
            hi_we = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (inject && i == 9) begin
                start = 1'b1; op = 2'b10; rs_data = 32'd99; rt_data = 32'd5;
            end
            if (inject && i == 14) begin
                hi_we = 1'b1; mt_wdata = 32'hDEAD;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_lit(input string name, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int bc;
        bit seen;
        issue(o, a, b);
        wait_done(1'b0, bc, seen);
        chk({name, "_hi"}, hi, ehi);
        chk({name, "_lo"}, lo, elo);
        chk({name, "_model_hi"}, m_hi, ehi);
        chk({name, "_model_lo"}, m_lo, elo);
        chk({name, "_busy_cycles"}, 32'(bc), 32'd33);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int  bc;
        bit  seen;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_lit("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        chk("done_busy_low", {31'b0, busy}, 32'd0);
        @(negedge clk);
        chk("done_single_pulse", {31'b0, done}, 32'd0);
        run_lit("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_lit("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_lit("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_lit("divu_zero", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
        run_lit("div_zero_neg", 2'b10, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF);

        issue(2'b01, 32'd6, 32'd7);
        wait_done(1'b1, bc, seen);
        chk("inject_hi", hi, 32'd0);
        chk("inject_lo", lo, 32'd42);
        chk("inject_busy_cycles", 32'(bc), 32'd33);
        hi_we = 1'b1; mt_wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_lo", lo, 32'd42);

        issue(2'b10, 32'd1000, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'b0, busy}, 32'd0);
        chk("async_rst_done", {31'b0, done}, 32'd0);
        chk("async_rst_hi", hi, 32'd0);
        chk("async_rst_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_lit("after_rst", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 3) == 0);
            op       = 2'($urandom_range(0, 3));
            rs_data  = pick();
            rt_data  = pick();
            hi_we    = ($urandom_range(0, 5) == 0);
            lo_we    = ($urandom_range(0, 5) == 0);
            mt_wdata = $urandom;
        end
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit for the HI/LO registers. It sits directly downstream of the register file read ports and consumes the rs/rt read data for MULT, MULTU, DIV and DIVU. It holds HI/LO for MFHI/MFLO and accepts MTHI/MTLO writes. It asserts busy so the control path stalls HI/LO accesses until the operation completes.

Parameters:
XLEN, 32, operand and HI/LO width; iteration count equals XLEN.

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request to begin an operation; sampled only in IDLE.
op  in  2  operation select: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
rs_data  in  XLEN  multiplicand or dividend (register file data1).
rt_data  in  XLEN  multiplier or divisor (register file data2).
hi_we  in  1  MTHI write enable.
lo_we  in  1  MTLO write enable.
mt_wdata  in  XLEN  MTHI/MTLO write data.
busy  out  1  operation in progress; HI/LO are not valid.
done  out  1  single-cycle pulse; HI/LO updated.
hi  out  XLEN  HI register.
lo  out  XLEN  LO register.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; busy=0, done=0, hi=0, lo=0; counter and internal operands cleared. Reset mid-operation aborts it with no HI/LO update.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE, edge E0 with start=1:
  - Latch op.
  - Latch |rs| and |rt| (magnitudes for signed ops; raw values for unsigned ops).
  - Latch the sign flags.
  - Clear the counter; go to CALC; busy=1.
- CALC, edges E1..E32: one iteration per edge.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract, 1 quotient bit per edge.
  - At the edge where counter==XLEN-1, go to FIX.
- FIX, edge E33:
  - Apply sign correction and load hi/lo.
  - busy->0; done=1 for exactly one cycle; go to IDLE.
- Total latency: done is high in the cycle following E33. busy is high for 33 cycles.
- Signed multiply: product negated if sign(rs)!=sign(rt). hi = upper XLEN bits, lo = lower XLEN bits of the 2*XLEN two's-complement result.
- Signed divide: quotient (lo) negated if signs differ. Remainder (hi) takes the sign of the dividend (truncation toward zero).
- Division by zero (rt_data==0): same latency; hi=rs_data (original value), lo={XLEN{1'b1}}; no exception.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no trap.
- start while busy=1: ignored; no effect on the running operation.
- hi_we/lo_we while busy=1: ignored (the control path must stall them).
- hi_we/lo_we in IDLE: hi or lo takes mt_wdata at the edge. Both may be written in the same cycle.
- start and hi_we/lo_we in the same IDLE cycle: start wins; the MT write is dropped.
- hi/lo hold their value at all times except on an FIX edge, an MT write or reset. Outputs are registered; no combinational path from inputs to hi/lo/busy/done.

Decomposition:
- Shared package muldiv_pkg holds:
  - XLEN default.
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU.
  - State encoding ST_IDLE/ST_CALC/ST_FIX.
- One natural sub-module, muldiv_iter_dp: the iteration datapath (accumulator, shift-add, shift-subtract, counter). muldiv_unit keeps the FSM, sign handling and HI/LO registers.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done one cycle after E33; busy high for exactly 33 cycles.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15).
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=100, rt=0 -> hi=0x00000064, lo=0xFFFFFFFF after the normal latency.
- Start MULTU 6*7:
  - Pulse start with other operands at E10 -> ignored.
  - hi_we with 0xDEAD at E15 -> ignored.
  - Result hi=0, lo=42.
  - Then hi_we=1, mt_wdata=0x1234 in IDLE -> hi=0x1234, lo unchanged.
- Assert rst_n=0 asynchronously at E20 of a DIV -> busy, done, hi, lo =0 immediately. After release, a new MULTU 3*4 gives lo=12.
